// File: rtl/keypad_scan_ctrl_if.sv
// Keypad scanner bus: column sense into the controller, row drive and key events out.
// The controller is the master; the keypad/consumer side is the slave.
interface keypad_scan_ctrl_if;
    logic [3:0] col;
    logic [3:0] row;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    modport master (
        input  col,
        output row,
        output key_valid,
        output key_code,
        output key_held
    );

    modport slave (
        output col,
        input  row,
        input  key_valid,
        input  key_code,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Emits one key_valid pulse per accepted press; key_code holds until the next accepted press.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV        = 24000,
    parameter int unsigned DEBOUNCE_CYCLES = 240000
) (
    input  logic                 clk,
    input  logic                 reset,
    keypad_scan_ctrl_if.master   kp
);

    localparam int unsigned DW  = $clog2(SCAN_DIV);
    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_SCAN       = 2'd0;
    localparam logic [1:0] ST_PRESS_DB   = 2'd1;
    localparam logic [1:0] ST_HELD       = 2'd2;
    localparam logic [1:0] ST_RELEASE_DB = 2'd3;

    logic [1:0]     r_state;
    logic [DW-1:0]  r_dwell;
    logic [DBW-1:0] r_db;
    logic [1:0]     r_row_idx;
    logic [3:0]     r_row;
    logic [3:0]     r_col_pat;
    logic [1:0]     r_col_idx;
    logic           r_key_valid;
    logic [3:0]     r_key_code;
    logic           r_key_held;

    logic           w_one_low;
    logic [1:0]     w_col_idx;
    logic           w_latched_bit;
    logic [1:0]     w_next_row_idx;

    function automatic logic [1:0] low_index(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: return 4'h1;
            4'b00_01: return 4'h2;
            4'b00_10: return 4'h3;
            4'b00_11: return 4'hA;
            4'b01_00: return 4'h4;
            4'b01_01: return 4'h5;
            4'b01_10: return 4'h6;
            4'b01_11: return 4'hB;
            4'b10_00: return 4'h7;
            4'b10_01: return 4'h8;
            4'b10_10: return 4'h9;
            4'b10_11: return 4'hC;
            4'b11_00: return 4'hE;
            4'b11_01: return 4'h0;
            4'b11_10: return 4'hF;
            default:  return 4'hD;
        endcase
    endfunction

    assign w_one_low      = ($countones(~kp.col) == 1);
    assign w_col_idx      = low_index(kp.col);
    assign w_latched_bit  = kp.col[r_col_idx];
    assign w_next_row_idx = r_row_idx + 2'd1;

    // Row index stays frozen outside SCAN, so "next row" after a key is latched+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_SCAN;
            r_dwell     <= '0;
            r_db        <= '0;
            r_row_idx   <= 2'd0;
            r_row       <= 4'b1110;
            r_col_pat   <= 4'hF;
            r_col_idx   <= 2'd0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    if (r_dwell == DWELL_LAST) begin
                        r_dwell <= '0;
                        if (w_one_low) begin
                            r_state   <= ST_PRESS_DB;
                            r_col_pat <= kp.col;
                            r_col_idx <= w_col_idx;
                            r_db      <= '0;
                        end else begin
                            r_row_idx <= w_next_row_idx;
                            r_row     <= row_drive(w_next_row_idx);
                        end
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                ST_PRESS_DB: begin
                    if (kp.col == r_col_pat) begin
                        if (r_db == DB_LAST) begin
                            r_state     <= ST_HELD;
                            r_key_valid <= 1'b1;
                            r_key_code  <= key_lut(r_row_idx, r_col_idx);
                            r_key_held  <= 1'b1;
                        end else begin
                            r_db <= r_db + 1'b1;
                        end
                    end else begin
                        r_state   <= ST_SCAN;
                        r_dwell   <= '0;
                        r_row_idx <= w_next_row_idx;
                        r_row     <= row_drive(w_next_row_idx);
                    end
                end
                ST_HELD: begin
                    if (w_latched_bit) begin
                        r_state <= ST_RELEASE_DB;
                        r_db    <= '0;
                    end
                end
                ST_RELEASE_DB: begin
                    if (!w_latched_bit) begin
                        r_state <= ST_HELD;
                    end else if (r_db == DB_LAST) begin
                        r_state    <= ST_SCAN;
                        r_key_held <= 1'b0;
                        r_dwell    <= '0;
                        r_row_idx  <= w_next_row_idx;
                        r_row      <= row_drive(w_next_row_idx);
                    end else begin
                        r_db <= r_db + 1'b1;
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

    assign kp.row       = r_row;
    assign kp.key_valid = r_key_valid;
    assign kp.key_code  = r_key_code;
    assign kp.key_held  = r_key_held;

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter: SCAN_DIV, 24000, clock cycles each row is driven before the scanner advances (range 2..2^20).
REQ-002 Parameter: DEBOUNCE_CYCLES, 240000, clock cycles a press or release must be stable before it is accepted (range 2..2^24).
REQ-003 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  reset, synchronous, active-high.
REQ-005 Port: col  input  4  keypad columns, already synchronized, active-low (0 = key closed in the driven row).
REQ-006 Port: row  output  4  keypad row drive, active-low, exactly one bit low at all times.
REQ-007 Port: key_valid  output  1  single-cycle pulse marking one accepted keypress.
REQ-008 Port: key_code  output  4  hex code of the last accepted key; held until the next accepted key.
REQ-009 Port: key_held  output  1  high while an accepted key remains pressed, including release debounce.

Function
REQ-010 The key map SHALL be: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E,0,F,D, with col0..col3 left to right; the code is the hex value of the key.
REQ-011 The FSM SHALL have four states: SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-012 SCAN: row index SHALL advance 0->1->2->3->0 every SCAN_DIV cycles; col SHALL be sampled only on the last dwell cycle of each row.
REQ-013 SCAN -> PRESS_DB when the sampled col has exactly one low bit; the row index and column are latched, the row stays frozen, and the debounce counter clears.
REQ-014 A sample with zero or two or more low bits SHALL be ignored: no transition, and scanning continues.
REQ-015 PRESS_DB: the counter SHALL increment each cycle while col equals the latched pattern; any mismatch SHALL return to SCAN, advance to the next row, and produce no event.
REQ-016 PRESS_DB -> HELD when the counter reaches DEBOUNCE_CYCLES-1 with a matching col; in that same cycle key_valid SHALL be 1 and key_code SHALL be updated.
REQ-017 key_valid SHALL be high for exactly one cycle per accepted press, and key_code SHALL be valid in that cycle.
REQ-018 HELD: row stays frozen; when the latched column bit reads 1, the FSM SHALL go to RELEASE_DB and clear the counter; other column bits are ignored, so no second key registers while held.
REQ-019 RELEASE_DB: the counter SHALL increment while the latched bit is 1; if the bit reads 0, the FSM SHALL return to HELD with no new event.
REQ-020 RELEASE_DB -> SCAN when the counter reaches DEBOUNCE_CYCLES-1; scanning SHALL resume at the next row (latched+1 mod 4) with a fresh dwell.
REQ-021 key_held SHALL be 1 in HELD and RELEASE_DB, and 0 otherwise.
REQ-022 Counters SHALL saturate and never wrap; the dwell counter width is ceil(log2(SCAN_DIV)), and the debounce counter width is ceil(log2(DEBOUNCE_CYCLES)).
REQ-023 All outputs SHALL be registered; row changes only on a clock edge, so col settles for at least SCAN_DIV-1 cycles before sampling.

Reset
REQ-024 When reset=1 on a rising edge, the block SHALL set: state SCAN, row = 4'b1110, key_valid = 0, key_code = 4'h0, key_held = 0, and both counters = 0.
REQ-025 Reset SHALL take priority over every transition, including a reset in PRESS_DB, HELD or RELEASE_DB, and SHALL emit no key_valid.
REQ-026 After reset deasserts, the first row sample SHALL occur SCAN_DIV cycles later.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-027 Reset, col=4'hF held for 64 cycles -> row sequence 1110,1101,1011,0111 repeating every 16 cycles; key_valid stays 0.
REQ-028 Key "6" (row1, col2 low while row=1101), stable -> one key_valid pulse with key_code=4'h6 8 cycles after latch; key_held=1; row frozen at 1101.
REQ-029 Press "9" with a bounce (col2 high for 1 cycle at debounce cycle 3) -> return to SCAN, no pulse; a stable re-press then yields key_code=4'h9 exactly once.
REQ-030 While "6" is held, release for 3 cycles and then press again -> no second pulse; a full 8-cycle release -> key_held=0 and scanning resumes at row2 (1011).
REQ-031 Keys "1" and "2" pressed together (row0, col=4'b1100) -> no event; releasing "2" -> key_code=4'h1 pulse.
REQ-032 Reset asserted in HELD -> next cycle row=1110, key_held=0, key_code=0, no pulse; the same key still held afterwards is re-detected as a fresh press.
